// File: rtl/regfile_pkg.sv
// Shared defaults and buffer state encoding for the register file read port.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_ADDR  = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/rsp_skid_buf.sv
// Two-entry in-order {addr,data} response buffer; head entry drives the outputs,
// skid entry absorbs one extra accept while the consumer stalls.
module rsp_skid_buf #(
    parameter int AW = regfile_pkg::ADDR_WIDTH,
    parameter int DW = regfile_pkg::DATA_WIDTH
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] in_addr_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_addr_o,
    output logic [DW-1:0] out_data_o
);
    import regfile_pkg::*;

    buf_state_e    state_q, state_d;
    logic [AW-1:0] head_addr_q, head_addr_d, skid_addr_q, skid_addr_d;
    logic [DW-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic          push, pop;

    assign push = in_valid_i && (state_q != ST_TWO);
    assign pop  = out_ready_i && (state_q != ST_EMPTY);

    always_comb begin
        state_d     = state_q;
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d     = ST_ONE;
                    head_addr_d = in_addr_i;
                    head_data_d = in_data_i;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_d     = ST_TWO;
                    skid_addr_d = in_addr_i;
                    skid_data_d = in_data_i;
                end else if (pop && !push) begin
                    state_d = ST_EMPTY;
                end else if (push && pop) begin
                    // old head leaves on this edge, new entry takes its place
                    head_addr_d = in_addr_i;
                    head_data_d = in_data_i;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d     = ST_ONE;
                    head_addr_d = skid_addr_q;
                    head_data_d = skid_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_EMPTY;
            head_addr_q <= '0;
            head_data_q <= '0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_addr_o  = head_addr_q;
    assign out_data_o  = head_data_q;

endmodule

// File: rtl/regfile_read_port.sv
// Registered read port of the register file: select, zero-register forcing and
// optional same-cycle write bypass (REG_READ_BYPASS_EN) feeding a 2-entry response buffer.
module regfile_read_port #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_bus,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ADDR_WIDTH-1:0]          rsp_addr,
    output logic [DATA_WIDTH-1:0]          rsp_data
);
    import regfile_pkg::*;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  is_zero;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
        assign regs[i] = reg_bus[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign is_zero = (ZERO_REG != 0) && (req_addr == ADDR_WIDTH'(ZERO_ADDR));

    always_comb begin
        sel_data = regs[req_addr];
`ifdef REG_READ_BYPASS_EN
        if (wr_en && (wr_addr == req_addr))
            sel_data = wr_data;
`endif
        if (is_zero)
            sel_data = '0;
    end

`ifndef REG_READ_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    rsp_skid_buf #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .clr_n       (clr_n),
        .in_valid_i  (req_valid),
        .in_ready_o  (req_ready),
        .in_addr_i   (req_addr),
        .in_data_i   (sel_data),
        .out_valid_o (rsp_valid),
        .out_ready_i (rsp_ready),
        .out_addr_o  (rsp_addr),
        .out_data_o  (rsp_data)
    );

endmodule
